video_unpack_reader: RTL

Read-side counterpart of the downsampling writer: fetches packed 256-bit words (16 × RGB565) for one tiled video window back from DDR in fixed-length bursts and buffers them in a word FIFO. It unpacks the words into a pixel stream driven by the display timing of that window. It sits between the DDR read arbiter and the multi-window splicing mixer, one instance per window. Single clock domain: DDR read data arrives already synchronised to clk.

---
 rtl/video_unpack_reader_if.sv | 13 +
 rtl/video_unpack_reader.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/video_unpack_reader_if.sv
// DDR read-side bus between a window reader (master) and the DDR read arbiter (slave).
interface video_unpack_reader_if #(
    parameter int W = 256
);
    logic         rd_req;
    logic         rd_req_ack;
    logic [3:0]   trans_id;
    logic [W-1:0] ddr_data;
    logic         ddr_valid;

    modport master (output rd_req, trans_id, input rd_req_ack, ddr_data, ddr_valid);
    modport slave  (input rd_req, trans_id, output rd_req_ack, ddr_data, ddr_valid);
endinterface

// File: rtl/video_unpack_reader.sv
// Per-window DDR reader: fetches packed RGB565 words in bursts into a word FIFO and
// unpacks them into a pixel stream paced by the window's display timing.
module video_unpack_reader #(
    parameter int         DQ_WIDTH     = 32,
    parameter logic [3:0] IMAGE_TAG    = 4'd1,
    parameter int         VIDEO_WIDTH  = 320,
    parameter int         VIDEO_HEIGHT = 180,
    parameter int         BURST_LEN    = 16,
    parameter int         FIFO_AW      = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         vs_in,
    input  logic                         de_in,
    video_unpack_reader_if.master        rd_bus,
    output logic [15:0]                  rgb565_out,
    output logic                         de_out,
    output logic                         row_end_flag,
    output logic                         frame_end_flag,
    output logic                         underflow
);
    localparam int W      = DQ_WIDTH * 8;
    localparam int DEPTH  = 2 ** FIFO_AW;
    localparam int WPF    = VIDEO_WIDTH * VIDEO_HEIGHT / 16;
    localparam int WL_W   = $clog2(WPF + 1);
    localparam int CNT_W  = FIFO_AW + 1;
    localparam int COL_W  = $clog2(VIDEO_WIDTH + 1);
    localparam int LINE_W = $clog2(VIDEO_HEIGHT + 1);

    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  BURST_C   = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0]  BEAT_LAST = CNT_W'(BURST_LEN - 1);
    localparam logic [WL_W-1:0]   WPF_C     = WL_W'(WPF);
    localparam logic [WL_W-1:0]   BURST_WL  = WL_W'(BURST_LEN);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(VIDEO_WIDTH - 1);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(VIDEO_HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, REQ, DATA, DRAIN} state_t;
    state_t state_q, state_d;

    logic              vs_d, vs_rise;
    logic [WL_W-1:0]   words_left;
    logic [CNT_W-1:0]  beat_cnt;
    logic [CNT_W-1:0]  wr_ptr, rd_ptr, fifo_cnt, reserved, free_words;
    logic [W-1:0]      mem [DEPTH];
    logic [W-1:0]      head;
    logic              fifo_empty, wr_en, pop, beat_last;
    logic [3:0]        pix_sel;
    logic [15:0]       pixel;
    logic [COL_W-1:0]  col_cnt;
    logic [LINE_W-1:0] line_cnt;
    logic              col_last;

    assign vs_rise    = vs_in & ~vs_d;
    assign fifo_cnt   = wr_ptr - rd_ptr;
    assign fifo_empty = (fifo_cnt == '0);
    // Space still owed to the burst in flight is counted as used, so a new request can never overflow.
    assign reserved   = (state_q == DATA) ? (BURST_C - beat_cnt) : '0;
    assign free_words = DEPTH_C - fifo_cnt - reserved;
    assign beat_last  = rd_bus.ddr_valid && (beat_cnt == BEAT_LAST);
    // A beat landing on the new-frame edge belongs to the old frame and is dropped with it.
    assign wr_en      = (state_q == DATA) && rd_bus.ddr_valid && !vs_rise;
    assign head       = mem[rd_ptr[FIFO_AW-1:0]];
    assign pixel      = 16'(head >> {pix_sel, 4'd0});
    assign pop        = de_in && !fifo_empty && (pix_sel == 4'd15);
    assign col_last   = (col_cnt == COL_LAST);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            state_q          <= IDLE;
            vs_d             <= 1'b0;
            rd_bus.trans_id  <= 4'd0;
        end else begin
            state_q          <= state_d;
            vs_d             <= vs_in;
            rd_bus.trans_id  <= IMAGE_TAG;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
        state_d       = state_q;
        rd_bus.rd_req = 1'b0;
        case (state_q)
            IDLE:  if (free_words >= BURST_C && words_left >= BURST_WL) state_d = REQ;
            REQ: begin
                rd_bus.rd_req = 1'b1;
                if (rd_bus.rd_req_ack) state_d = DATA;
            end
            DATA: begin
                if (beat_last)    state_d = IDLE;
                else if (vs_rise) state_d = DRAIN;
            end
            DRAIN: if (beat_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            words_left <= '0;
            beat_cnt   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            if (vs_rise)    words_left <= WPF_C;
            else if (wr_en) words_left <= words_left - 1'b1;

            if (state_q == REQ && rd_bus.rd_req_ack)
                beat_cnt <= '0;
            else if ((state_q == DATA || state_q == DRAIN) && rd_bus.ddr_valid)
                beat_cnt <= beat_cnt + 1'b1;

            if (vs_rise) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_en) wr_ptr <= wr_ptr + 1'b1;
                if (pop)   rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // NOTE: the storage array is deliberately not reset; occupancy is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[FIFO_AW-1:0]] <= rd_bus.ddr_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pix_sel        <= '0;
            col_cnt        <= '0;
            line_cnt       <= '0;
            rgb565_out     <= '0;
            de_out         <= 1'b0;
            row_end_flag   <= 1'b0;
            frame_end_flag <= 1'b0;
            underflow      <= 1'b0;
        end else begin
            de_out         <= de_in;
            row_end_flag   <= de_in && col_last;
            frame_end_flag <= de_in && col_last && (line_cnt == LINE_LAST);

            if (de_in) begin
                if (fifo_empty) begin
                    rgb565_out <= 16'h0000;
                end else begin
                    rgb565_out <= pixel;
                    pix_sel    <= pix_sel + 1'b1;
                end
            end

            if (vs_rise) begin
                pix_sel  <= '0;
                col_cnt  <= '0;
                line_cnt <= '0;
            end else if (de_in) begin
                col_cnt <= col_last ? '0 : col_cnt + 1'b1;
                if (col_last) line_cnt <= (line_cnt == LINE_LAST) ? '0 : line_cnt + 1'b1;
            end

            if (vs_rise)                  underflow <= 1'b0;
            else if (de_in && fifo_empty) underflow <= 1'b1;
        end
    end
endmodule
